// File: rtl/noc_pkg.sv
// noc_pkg: shared flit field layout and arbiter state type for the NoC ingress buffer.
package noc_pkg;
  // Field positions are counted downward from the flit MSB, so they hold for any flit width.
  localparam int FLIT_VALID  = 0;
  localparam int FLIT_HEAD   = 1;
  localparam int FLIT_TAIL   = 2;
  localparam int FLIT_VC_LSB = 3;
  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;
  function automatic int flit_vc(input logic [63:0] flit, input int width, input int vcw);
    return int'((flit >> (width - FLIT_VC_LSB - vcw)) & ((64'd1 << vcw) - 64'd1));
  endfunction
endpackage

// File: rtl/vc_fifo.sv
// vc_fifo: one virtual-channel FIFO, arbitrary depth, accepts push and pop together even when full.
module vc_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 10
) (
  input  logic             clk_noc,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic wr, rd;
  assign rd    = pop && !empty;
  assign wr    = push && (!full || rd);
  assign empty = count == '0;
  assign full  = count == CW'(DEPTH);
  assign dout  = mem[rd_ptr];
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction
  always_ff @(posedge clk_noc or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= nxt(wr_ptr);
      if (rd) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(wr) - CW'(rd);
    end
  always_ff @(posedge clk_noc)
    if (wr) mem[wr_ptr] <= din;
endmodule

// File: rtl/noc_vc_buffer.sv
// noc_vc_buffer: per-VC ingress FIFOs with credit return and a wormhole round-robin output arbiter.
module noc_vc_buffer
  import noc_pkg::*;
#(
  parameter int WIDTH_NOC        = 9,
  parameter int NUM_VC           = 2,
  parameter int DEPTH_PER_VC     = 10,
  parameter int VC_ADDRESS_WIDTH = $clog2(NUM_VC)
) (
  input  logic                 clk_noc,
  input  logic                 rst_n,
  input  logic [WIDTH_NOC-1:0] noc_flit_in,
  output logic [NUM_VC-1:0]    noc_credits_out,
  output logic [WIDTH_NOC-1:0] out_flit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_VC-1:0]    occupancy_empty,
  output logic                 overflow_err
);
  localparam int VALID_B = WIDTH_NOC - 1 - FLIT_VALID;
  localparam int HEAD_B  = WIDTH_NOC - 1 - FLIT_HEAD;
  localparam int TAIL_B  = WIDTH_NOC - 1 - FLIT_TAIL;
  localparam int VW      = VC_ADDRESS_WIDTH;
  logic [NUM_VC-1:0] push, pop, empty, full;
  logic [WIDTH_NOC-1:0] head [NUM_VC];
  logic [VW-1:0] in_vc, gnt, idx, rr, rr_next, lock_vc, lock_next;
  arb_state_e state, state_next;
  logic fire, found;
  assign in_vc = VW'(flit_vc(64'(noc_flit_in), WIDTH_NOC, VW));
  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign push[v] = noc_flit_in[VALID_B] && in_vc == VW'(v);
    assign pop[v]  = fire && gnt == VW'(v);
    vc_fifo #(.WIDTH(WIDTH_NOC), .DEPTH(DEPTH_PER_VC)) u_fifo (
      .clk_noc (clk_noc),
      .rst_n   (rst_n),
      .push    (push[v]),
      .pop     (pop[v]),
      .din     (noc_flit_in),
      .dout    (head[v]),
      .empty   (empty[v]),
      .full    (full[v])
    );
  end
  assign occupancy_empty = empty;
  assign out_flit        = head[gnt];
  // In IDLE only a head flit may start a packet; a stray body flit stalls its VC.
  always_comb begin
    state_next = state;
    lock_next  = lock_vc;
    rr_next    = rr;
    gnt        = lock_vc;
    idx        = '0;
    found      = 1'b0;
    if (state == ARB_LOCKED) out_valid = !empty[lock_vc];
    else begin
      for (int i = 0; i < NUM_VC; i++) begin
        idx = VW'((int'(rr) + i) % NUM_VC);
        if (!found && !empty[idx] && head[idx][HEAD_B]) begin
          found = 1'b1;
          gnt   = idx;
        end
      end
      out_valid = found;
    end
    fire = out_valid && out_ready;
    if (fire && head[gnt][TAIL_B]) begin
      state_next = ARB_IDLE;
      rr_next    = VW'((int'(gnt) + 1) % NUM_VC);
    end else if (fire) begin
      state_next = ARB_LOCKED;
      lock_next  = gnt;
    end
  end
  always_ff @(posedge clk_noc or negedge rst_n)
    if (!rst_n) begin
      state           <= ARB_IDLE;
      lock_vc         <= '0;
      rr              <= '0;
      noc_credits_out <= '0;
      overflow_err    <= 1'b0;
    end else begin
      state           <= state_next;
      lock_vc         <= lock_next;
      rr              <= rr_next;
      noc_credits_out <= fire ? NUM_VC'(1) << gnt : '0;
      overflow_err    <= overflow_err | (|(push & full & ~pop));
    end
endmodule

// File: tb/tb_noc_vc_buffer.sv
// tb_noc_vc_buffer: directed checks of ordering, credits, overflow, wrap, round-robin and async reset.
module tb_noc_vc_buffer;
  logic clk_noc = 0, rst_n = 0, out_ready = 0;
  logic [8:0] noc_flit_in = '0;
  logic [1:0] noc_credits_out, occupancy_empty;
  logic [8:0] out_flit;
  logic out_valid, overflow_err;
  int n_assert = 0, n_fail = 0;
  int cred [2];
  logic [8:0] popq [$];
  logic [8:0] expq [$];

  noc_vc_buffer #(.WIDTH_NOC(9), .NUM_VC(2), .DEPTH_PER_VC(10), .VC_ADDRESS_WIDTH(1)) dut (
    .clk_noc         (clk_noc),
    .rst_n           (rst_n),
    .noc_flit_in     (noc_flit_in),
    .noc_credits_out (noc_credits_out),
    .out_flit        (out_flit),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .occupancy_empty (occupancy_empty),
    .overflow_err    (overflow_err)
  );

  always #5 clk_noc = ~clk_noc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Records the pop decided just before the edge, then tallies the credits produced by that edge.
  task automatic cycle();
    #1;
    if (out_valid && out_ready) popq.push_back(out_flit);
    @(posedge clk_noc);
    #1;
    chk("credit_onehot", 32'($countones(noc_credits_out) <= 1), 1);
    for (int v = 0; v < 2; v++) if (noc_credits_out[v]) cred[v]++;
  endtask

  task automatic clear();
    popq.delete();
    cred[0] = 0;
    cred[1] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_noc);
    rst_n = 0;
    noc_flit_in = '0;
    out_ready = 0;
    repeat (2) @(negedge clk_noc);
    rst_n = 1;
    clear();
  endtask

  task automatic chk_seq(input string tag);
    logic [31:0] o;
    chk({tag, "_count"}, popq.size(), expq.size());
    foreach (expq[i]) begin
      o = (i < popq.size()) ? 32'(popq[i]) : 'x;
      chk(tag, o, 32'(expq[i]));
    end
  endtask

  function automatic logic [8:0] f4(input int i);
    return 9'h100 | (i == 0 ? 9'h080 : 9'h000) | (i == 24 ? 9'h040 : 9'h000) | 9'(i);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk_noc);
    chk("rst_credits", noc_credits_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_empty", occupancy_empty, 2'b11);
    chk("rst_ovf", overflow_err, 0);
    rst_n = 1;
    clear();
    // single-flit packet on VC0
    out_ready = 1;
    noc_flit_in = 9'h1C5;
    cycle();
    noc_flit_in = '0;
    chk("t1_valid", out_valid, 1);
    chk("t1_flit", out_flit, 9'h1C5);
    chk("t1_no_early_credit", noc_credits_out, 0);
    cycle();
    chk("t1_credit", noc_credits_out, 2'b01);
    chk("t1_drained", out_valid, 0);
    cycle();
    chk("t1_credit_pulse", noc_credits_out, 0);
    // interleaved 3-flit packets, VC0 head first
    clear();
    expq = '{9'h181, 9'h1A1, 9'h102, 9'h122, 9'h143, 9'h163};
    foreach (expq[i]) begin
      noc_flit_in = expq[i];
      cycle();
    end
    noc_flit_in = '0;
    repeat (8) cycle();
    expq = '{9'h181, 9'h102, 9'h143, 9'h1A1, 9'h122, 9'h163};
    chk_seq("t2_order");
    chk("t2_cred0", cred[0], 3);
    chk("t2_cred1", cred[1], 3);
    chk("t2_empty", occupancy_empty, 2'b11);
    // overflow with out_ready low
    clear();
    out_ready = 0;
    for (int i = 0; i < 10; i++) begin
      noc_flit_in = 9'h100 | 9'(i);
      cycle();
    end
    noc_flit_in = '0;
    chk("t3_ovf_before", overflow_err, 0);
    chk("t3_empty", occupancy_empty, 2'b10);
    noc_flit_in = 9'h11F;
    cycle();
    noc_flit_in = '0;
    chk("t3_ovf_set", overflow_err, 1);
    repeat (3) cycle();
    chk("t3_ovf_sticky", overflow_err, 1);
    chk("t3_no_valid", out_valid, 0);
    chk("t3_no_credit", cred[0] + cred[1], 0);
    // sustained push+pop on a full VC across pointer wrap
    do_reset();
    for (int i = 0; i < 10; i++) begin
      noc_flit_in = f4(i);
      cycle();
    end
    chk("t4_head_valid", out_valid, 1);
    chk("t4_head_flit", out_flit, 9'h180);
    for (int i = 10; i < 25; i++) begin
      noc_flit_in = f4(i);
      out_ready = 1;
      cycle();
      chk("t4_ovf_clear", overflow_err, 0);
    end
    out_ready = 0;
    noc_flit_in = 9'h11F;
    cycle();
    noc_flit_in = '0;
    chk("t4_still_full", overflow_err, 1);
    out_ready = 1;
    repeat (12) cycle();
    expq.delete();
    for (int i = 0; i < 25; i++) expq.push_back(f4(i));
    chk_seq("t4_order");
    chk("t4_cred0", cred[0], 25);
    chk("t4_empty", occupancy_empty, 2'b11);
    // round-robin between single-flit packets
    do_reset();
    expq = '{9'h1C1, 9'h1E2, 9'h1C3, 9'h1E4};
    foreach (expq[i]) begin
      noc_flit_in = expq[i];
      cycle();
    end
    noc_flit_in = '0;
    out_ready = 1;
    repeat (6) cycle();
    chk_seq("t5_rr");
    chk("t5_cred0", cred[0], 2);
    chk("t5_cred1", cred[1], 2);
    // asynchronous reset while VC1 is locked mid-packet
    clear();
    noc_flit_in = 9'h1A1;
    cycle();
    noc_flit_in = 9'h122;
    cycle();
    out_ready = 0;
    noc_flit_in = 9'h123;
    cycle();
    noc_flit_in = '0;
    cycle();
    chk("t6_locked_valid", out_valid, 1);
    chk("t6_locked_flit", out_flit, 9'h122);
    chk("t6_empty", occupancy_empty, 2'b01);
    out_ready = 1;
    #1;
    rst_n = 0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_empty", occupancy_empty, 2'b11);
    chk("t6_rst_credits", noc_credits_out, 0);
    chk("t6_rst_ovf", overflow_err, 0);
    @(posedge clk_noc);
    #1;
    chk("t6_rst_no_credit", noc_credits_out, 0);
    @(negedge clk_noc);
    rst_n = 1;
    clear();
    noc_flit_in = 9'h183;
    cycle();
    noc_flit_in = 9'h144;
    cycle();
    noc_flit_in = '0;
    repeat (3) cycle();
    expq = '{9'h183, 9'h144};
    chk_seq("t6_after");
    chk("t6_cred0", cred[0], 2);
    chk("t6_cred1", cred[1], 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/noc_vc_buffer.md
Name: noc_vc_buffer

Overview:
- NoC-side ingress stage that sits directly downstream of fabric_port_in and consumes its noc_flit_out stream.
- Stores incoming flits in per-VC FIFOs.
- Returns one credit per dequeued flit on noc_credits_out, which is wired to fabric_port_in's noc_credits_in.
- Forwards flits to the router/crossbar through a wormhole round-robin arbiter with a valid/ready handshake.

Parameters:
- WIDTH_NOC, 9, flit width including control bits.
- NUM_VC, 2, number of virtual channels.
- DEPTH_PER_VC, 10, FIFO entries per VC. Need not be a power of 2.
- VC_ADDRESS_WIDTH, $clog2(NUM_VC), width of the VC id field.

Ports:
- clk_noc, in, 1: NoC clock; single clock domain.
- rst_n, in, 1: asynchronous active-low reset.
- noc_flit_in, in, WIDTH_NOC: flit from fabric_port_in.
- noc_credits_out, out, NUM_VC: one-cycle credit pulse per VC.
- out_flit, out, WIDTH_NOC: flit to the downstream router.
- out_valid, out, 1: out_flit is valid.
- out_ready, in, 1: downstream accepts out_flit.
- occupancy_empty, out, NUM_VC: per-VC FIFO empty flag.
- overflow_err, out, 1: sticky error flag, set on a write to a full VC.

Behaviour:
- Clocking/reset: one clock, clk_noc. Reset is asynchronous, active-low (rst_n).
- Flit format, MSB first: [W-1] valid, [W-2] head, [W-3] tail, then VC_ADDRESS_WIDTH bits vc id, then payload in the remaining bits.
  - Defaults: bit8 valid, bit7 head, bit6 tail, bit5 vc, bits4:0 payload.
  - A flit with head=1 and tail=1 is a single-flit packet.
- Reset values:
  - All FIFO read/write pointers and counts cleared.
  - noc_credits_out=0, out_valid=0, occupancy_empty=all 1s, overflow_err=0.
  - Arbiter unlocked, round-robin pointer at VC0.
- Write: when noc_flit_in[W-1]=1, the full flit is pushed into FIFO[vc id] in that cycle. No ready signal on the input; upstream is credit-controlled.
- Pointers: wrap from DEPTH_PER_VC-1 to 0. Count width is $clog2(DEPTH_PER_VC+1).
- Full VC:
  - Push to a full VC with no simultaneous pop on that VC: flit dropped, overflow_err set. overflow_err clears only on reset.
  - Push and pop on the same full VC in the same cycle: both accepted, count unchanged, no error.
  - Push to an empty VC: visible at the FIFO head the next cycle. No fall-through.
- Arbiter states:
  - IDLE: if any VC head is valid and holds a head flit, grant the first such VC at or after the rr pointer (round-robin).
  - LOCKED(v): only VC v may be output, until its tail flit is popped.
- Transitions:
  - On popping a tail flit, return to IDLE and set the rr pointer to v+1 mod NUM_VC.
  - A single-flit packet (head=tail=1) never leaves IDLE. The grant happens and the pointer advances in the same cycle as the pop.
- Output:
  - out_valid=1 when the granted VC (locked, or selected in IDLE) is non-empty. out_flit is the head of that FIFO (combinational).
  - Pop occurs when out_valid && out_ready.
  - While LOCKED(v) and FIFO v is empty (mid-packet bubble), out_valid=0 and the lock is held. Other VCs may not interleave.
- Credits:
  - A pop on VC v causes noc_credits_out[v]=1 for exactly one cycle, registered: the cycle after the pop.
  - At most one credit bit is set per cycle.
- A non-head flit at a VC head while IDLE is a protocol violation. That flit is not granted; the VC stalls.
- A reset assertion mid-packet discards all contents and the lock immediately. No credits are emitted for discarded flits.

Decomposition:
- Package noc_pkg holds:
  - flit field index constants (FLIT_VALID, FLIT_HEAD, FLIT_TAIL, FLIT_VC_LSB);
  - a typedef for the arbiter state enum {ARB_IDLE, ARB_LOCKED};
  - a function extracting the vc id.
- Sub-module vc_fifo, parameterised by WIDTH and DEPTH, instantiated NUM_VC times. It exposes push, pop, head data, empty and full, handles wrap-around, and supports simultaneous push/pop when full.
- Arbiter, lock logic and credit registers live in the top level.

Test Plan:
1. Single-flit packet to VC0 (0x1C5: valid, head, tail, vc0, payload 5), out_ready=1.
   - out_valid rises the next cycle with out_flit=0x1C5.
   - noc_credits_out=2'b01 for one cycle, one cycle after the pop.
2. 3-flit packet on VC1 interleaved cycle-by-cycle with a 3-flit packet on VC0, VC0 head first.
   - Output is all three VC0 flits, then all three VC1 flits; no interleaving.
   - Six credits returned, three per VC.
3. Fill VC0 with 10 body flits while out_ready=0, then push an 11th.
   - overflow_err=1 and stays 1.
   - No credit emitted while out_ready=0.
   - occupancy_empty[0]=0.
4. Full VC0 with push and pop in the same cycle.
   - Count stays 10, overflow_err stays 0.
   - Read/write pointers wrap from 9 to 0 correctly: 25 sustained flits come out in order.
5. Both VCs hold head flits in IDLE, repeatedly.
   - Grants alternate VC0, VC1, VC0 as the rr pointer advances after each tail.
6. Assert rst_n low mid-packet (VC1 locked, 2 flits buffered).
   - Outputs go to reset values immediately (asynchronously), with no credit pulse.
   - After release, a new VC0 packet is granted normally.
